// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_pkg
// Brief   : Shared state encoding and defaults for the pipeline hazard controller.
// Revision: 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam int c_REG_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Pipeline-status inputs and pipeline-register control outputs.
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic             i_mem_stall;
    logic             i_id_valid;
    logic [REG_W-1:0] i_id_rs;
    logic [REG_W-1:0] i_id_rt;
    logic             i_id_uses_rs;
    logic             i_id_uses_rt;
    logic             i_id_hlt;
    logic             i_ex_lw;
    logic [REG_W-1:0] i_ex_rd;
    logic             i_ex_br_taken;
    logic             o_pc_wen;
    logic             o_ifid_wen;
    logic             o_ifid_flush;
    logic             o_idex_wen;
    logic             o_idex_flush;
    logic             o_halted;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_mem_stall, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs,
               i_id_uses_rt, i_id_hlt, i_ex_lw, i_ex_rd, i_ex_br_taken,
        input  o_pc_wen, o_ifid_wen, o_ifid_flush, o_idex_wen, o_idex_flush,
               o_halted, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_mem_stall, i_id_valid, i_id_rs, i_id_rt, i_id_uses_rs,
               i_id_uses_rt, i_id_hlt, i_ex_lw, i_ex_rd, i_ex_br_taken,
        output o_pc_wen, o_ifid_wen, o_ifid_flush, o_idex_wen, o_idex_flush,
               o_halted, o_stall_cnt, o_flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Brief   : Event counter that sticks at all-ones instead of wrapping.
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Load-use stall, branch squash, memory freeze and HLT drain control.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W        = c_REG_W_DEFAULT,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  wire              clk,
    input  wire              rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int                  c_DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DW-1:0]     c_DRAIN_LAST = c_DW'(DRAIN_CYCLES - 1);

    state_t            r_state;
    logic [c_DW-1:0]   r_drain_cnt;
    logic              r_halted;

    logic w_hazard;
    logic w_pc_wen, w_ifid_wen, w_ifid_flush, w_idex_wen, w_idex_flush;
    logic w_stall_inc, w_flush_inc, w_enter_drain;

    assign w_hazard = bus.i_id_valid & bus.i_ex_lw & (bus.i_ex_rd != '0) &
                      ((bus.i_id_uses_rs & (bus.i_id_rs == bus.i_ex_rd)) |
                       (bus.i_id_uses_rt & (bus.i_id_rt == bus.i_ex_rd)));

    always_comb begin
        w_pc_wen      = 1'b0;
        w_ifid_wen    = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_wen    = 1'b0;
        w_idex_flush  = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;
        w_enter_drain = 1'b0;
        // Outputs are forced quiet for as long as reset is held.
        if (rst) begin
            case (r_state)
                ST_RUN: begin
                    if (bus.i_mem_stall) begin
                        w_pc_wen = 1'b0;
                    end else if (bus.i_ex_br_taken) begin
                        w_pc_wen     = 1'b1;
                        w_ifid_wen   = 1'b1;
                        w_idex_wen   = 1'b1;
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                        w_flush_inc  = 1'b1;
                    end else if (w_hazard) begin
                        w_idex_wen   = 1'b1;
                        w_idex_flush = 1'b1;
                        w_stall_inc  = 1'b1;
                    end else if (bus.i_id_valid && bus.i_id_hlt) begin
                        w_idex_wen    = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_enter_drain = 1'b1;
                    end else begin
                        w_pc_wen   = 1'b1;
                        w_ifid_wen = 1'b1;
                        w_idex_wen = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.i_mem_stall) begin
                        w_idex_wen   = 1'b1;
                        w_idex_flush = 1'b1;
                    end
                end
                default: w_pc_wen = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_enter_drain) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (!bus.i_mem_stall) begin
                        if (r_drain_cnt == c_DRAIN_LAST) begin
                            r_state  <= ST_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                end
                ST_HALTED: r_halted <= 1'b1;
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .o_cnt (bus.o_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_flush_inc),
        .o_cnt (bus.o_flush_cnt)
    );

    assign bus.o_pc_wen     = w_pc_wen;
    assign bus.o_ifid_wen   = w_ifid_wen;
    assign bus.o_ifid_flush = w_ifid_flush;
    assign bus.o_idex_wen   = w_idex_wen;
    assign bus.o_idex_flush = w_idex_flush;
    assign bus.o_halted     = r_halted;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed vectors with a queued-expectation scoreboard.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    typedef struct packed {
        logic       r, ms, iv;
        logic [3:0] rs, rt;
        logic       urs, urt, hlt, lw;
        logic [3:0] rd;
        logic       br;
    } vin_t;

    typedef struct packed {
        logic       pc, ifid, ifl, idex, idfl, hal;
        logic [3:0] sc, fc;
    } vexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vexp_t exp_q[$];
    string name_q[$];

    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(4)) ifc ();

    pipe_hazard_ctrl #(.REG_W(4), .DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic vin_t vi(logic r, logic ms, logic iv, logic [3:0] rs, logic [3:0] rt,
                                logic urs, logic urt, logic hlt, logic lw, logic [3:0] rd, logic br);
        vi = '{r, ms, iv, rs, rt, urs, urt, hlt, lw, rd, br};
    endfunction

    function automatic vexp_t ve(logic pc, logic ifid, logic ifl, logic idex, logic idfl,
                                 logic hal, logic [3:0] sc, logic [3:0] fc);
        ve = '{pc, ifid, ifl, idex, idfl, hal, sc, fc};
    endfunction

    task automatic drive(input vin_t v, input vexp_t e, input string nm);
        @(posedge clk);
        #1;
        rst               = v.r;
        ifc.i_mem_stall   = v.ms;
        ifc.i_id_valid    = v.iv;
        ifc.i_id_rs       = v.rs;
        ifc.i_id_rt       = v.rt;
        ifc.i_id_uses_rs  = v.urs;
        ifc.i_id_uses_rt  = v.urt;
        ifc.i_id_hlt      = v.hlt;
        ifc.i_ex_lw       = v.lw;
        ifc.i_ex_rd       = v.rd;
        ifc.i_ex_br_taken = v.br;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one expectation is consumed per cycle, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vexp_t e;
            vexp_t a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{ifc.o_pc_wen, ifc.o_ifid_wen, ifc.o_ifid_flush, ifc.o_idex_wen,
                   ifc.o_idex_flush, ifc.o_halted, ifc.o_stall_cnt, ifc.o_flush_cnt};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got pc/ifid/ifl/idex/idfl/hal=%b%b%b%b%b%b sc=%h fc=%h, want %b%b%b%b%b%b sc=%h fc=%h",
                         nm, a.pc, a.ifid, a.ifl, a.idex, a.idfl, a.hal, a.sc, a.fc,
                         e.pc, e.ifid, e.ifl, e.idex, e.idfl, e.hal, e.sc, e.fc);
            end
        end
    end

    initial begin
        vin_t idle;
        vin_t haz;
        idle = vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        haz  = vi(1, 0, 1, 3, 0, 1, 0, 0, 1, 3, 0);
        ifc.i_mem_stall = 0; ifc.i_id_valid = 0; ifc.i_id_rs = 0; ifc.i_id_rt = 0;
        ifc.i_id_uses_rs = 0; ifc.i_id_uses_rt = 0; ifc.i_id_hlt = 0; ifc.i_ex_lw = 0;
        ifc.i_ex_rd = 0; ifc.i_ex_br_taken = 0;

        drive(vi(0, 0, 1, 3, 0, 1, 0, 0, 1, 3, 0), ve(0,0,0,0,0,0, 0,0), "reset_hazard_in");
        drive(idle,                                  ve(1,1,0,1,0,0, 0,0), "idle");
        drive(haz,                                   ve(0,0,0,1,1,0, 0,0), "hazard_rs");
        drive(idle,                                  ve(1,1,0,1,0,0, 1,0), "after_hazard");
        drive(vi(1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0),   ve(1,1,0,1,0,0, 1,0), "rd_zero");
        drive(vi(1, 0, 1, 3, 0, 0, 0, 0, 1, 3, 0),   ve(1,1,0,1,0,0, 1,0), "no_use_rs");
        drive(vi(1, 0, 1, 0, 5, 0, 1, 0, 1, 5, 0),   ve(0,0,0,1,1,0, 1,0), "hazard_rt");
        drive(vi(1, 0, 1, 3, 0, 1, 0, 0, 0, 3, 0),   ve(1,1,0,1,0,0, 2,0), "not_lw");
        drive(vi(1, 0, 0, 3, 0, 1, 0, 0, 1, 3, 0),   ve(1,1,0,1,0,0, 2,0), "id_invalid");
        drive(vi(1, 0, 1, 3, 0, 1, 0, 0, 1, 3, 1),   ve(1,1,1,1,1,0, 2,0), "branch_masks_hazard");
        drive(vi(1, 1, 1, 3, 0, 1, 0, 0, 1, 3, 0),   ve(0,0,0,0,0,0, 2,1), "memstall_hazard");
        drive(vi(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1),   ve(0,0,0,0,0,0, 2,1), "memstall_branch");
        drive(idle,                                  ve(1,1,0,1,0,0, 2,1), "idle_after_stall");
        drive(vi(1, 0, 1, 3, 0, 1, 0, 1, 1, 3, 0),   ve(0,0,0,1,1,0, 2,1), "hazard_holds_hlt");
        drive(vi(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0),   ve(0,0,0,1,1,0, 3,1), "hlt_enter_drain");
        drive(vi(1, 0, 1, 3, 0, 1, 0, 0, 1, 3, 1),   ve(0,0,0,1,1,0, 3,1), "drain0_ignores_br");
        drive(vi(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),   ve(0,0,0,0,0,0, 3,1), "drain_memstall_a");
        drive(vi(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),   ve(0,0,0,0,0,0, 3,1), "drain_memstall_b");
        drive(idle,                                  ve(0,0,0,1,1,0, 3,1), "drain1");
        drive(idle,                                  ve(0,0,0,1,1,0, 3,1), "drain2");
        drive(vi(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1),   ve(0,0,0,0,0,1, 3,1), "halted_br");
        drive(vi(1, 0, 1, 3, 0, 1, 0, 1, 1, 3, 0),   ve(0,0,0,0,0,1, 3,1), "halted_hazard");
        drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   ve(0,0,0,0,0,0, 0,0), "reset_from_halted");
        drive(idle,                                  ve(1,1,0,1,0,0, 0,0), "run_after_reset");

        drive(vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1),   ve(1,1,1,1,1,0, 0,0), "branch");
        drive(vi(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0),   ve(0,0,0,1,1,0, 0,1), "hlt_again");
        drive(haz,                                   ve(0,0,0,1,1,0, 0,1), "drain0_hazard");
        drive(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),   ve(0,0,0,0,0,0, 0,0), "reset_mid_drain");
        drive(vi(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0),   ve(0,0,0,0,0,0, 0,0), "reset_held");
        drive(idle,                                  ve(1,1,0,1,0,0, 0,0), "run_after_drain_reset");

        for (int k = 0; k < 20; k++) begin
            drive(haz, ve(0,0,0,1,1,0, (k > 15) ? 4'hF : 4'(k), 0), "hazard_saturate");
        end
        drive(idle,                                  ve(1,1,0,1,0,0, 4'hF, 0), "saturated_hold");

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
